// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for the VGA timing path.
// Imported by the timing counter and by the sync generators.
package vga_timing_pkg;

  localparam int CNT_W     = 12;
  localparam int CNT_LIMIT = 1 << CNT_W;

  // 640x480@60 defaults
  localparam int DEF_HPIXEL        = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_PULSE  = 96;
  localparam int DEF_H_BACK_PORCH  = 48;
  localparam int DEF_VPIXEL        = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_PULSE  = 2;
  localparam int DEF_V_BACK_PORCH  = 33;
  localparam int DEF_CLK_DIV       = 4;

  typedef logic [CNT_W-1:0] count_t;

  typedef struct packed {
    count_t h;
    count_t v;
  } raster_pos_t;

  function automatic int htotal(input int pixel, input int front, input int sync, input int back);
    return pixel + front + sync + back;
  endfunction

  function automatic int vtotal(input int pixel, input int front, input int sync, input int back);
    return pixel + front + sync + back;
  endfunction

  function automatic bit total_fits(input int total);
    return (total >= 1) && (total <= CNT_LIMIT);
  endfunction

endpackage

// File: rtl/vga_pixel_tick_divider.sv
// Divides the system clock into a one-clk pixel strobe; the phase holds while en is low.
module vga_pixel_tick_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             div_last;

  assign div_last = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (en) begin
      div_cnt_d = div_last ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // With CLK_DIV=1 the counter is stuck at 0 == DIV_LAST, so the strobe follows en.
  assign pix_tick = en && div_last;

endmodule

// File: rtl/vga_timing_counter.sv
// Raster position counters for the VGA path plus line/frame strobes and active-video decode.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int HPIXEL        = DEF_HPIXEL,
  parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_PULSE  = DEF_H_SYNC_PULSE,
  parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
  parameter int VPIXEL        = DEF_VPIXEL,
  parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_PULSE  = DEF_V_SYNC_PULSE,
  parameter int V_BACK_PORCH  = DEF_V_BACK_PORCH,
  parameter int CLK_DIV       = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_tick,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             video_active,
  output logic             line_end,
  output logic             frame_end
);

  localparam int HTOTAL = htotal(HPIXEL, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
  localparam int VTOTAL = vtotal(VPIXEL, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);

  if (CLK_DIV < 1 || !total_fits(HTOTAL) || !total_fits(VTOTAL)) begin : g_bad_params
    $fatal(1, "vga_timing_counter: need CLK_DIV >= 1 and HTOTAL/VTOTAL <= %0d", CNT_LIMIT);
  end

  localparam count_t H_LAST = count_t'(HTOTAL - 1);
  localparam count_t V_LAST = count_t'(VTOTAL - 1);
  localparam count_t H_VIS  = count_t'(HPIXEL);
  localparam count_t V_VIS  = count_t'(VPIXEL);

  raster_pos_t pos_q;
  raster_pos_t pos_d;
  logic        h_wrap;
  logic        v_wrap;

  vga_pixel_tick_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pix_tick (pix_tick)
  );

  assign h_wrap = (pos_q.h == H_LAST);
  assign v_wrap = (pos_q.v == V_LAST);

  // Both counters wrap on the same edge at the frame boundary.
  always_comb begin
    pos_d = pos_q;
    if (pix_tick) begin
      if (h_wrap) begin
        pos_d.h = '0;
        pos_d.v = v_wrap ? '0 : pos_q.v + count_t'(1);
      end else begin
        pos_d.h = pos_q.h + count_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign hCount       = pos_q.h;
  assign vCount       = pos_q.v;
  assign line_end     = pix_tick && h_wrap;
  assign frame_end    = line_end && v_wrap;
  assign video_active = (pos_q.h < H_VIS) && (pos_q.v < V_VIS);

endmodule

// File: tb/tb_vga_timing_counter.sv
// Scoreboard bench for vga_timing_counter across three raster configurations.
module tb_vga_timing_counter;

  localparam int NCFG = 3;
  localparam int CFG_HP  [NCFG] = '{640, 8, 20};
  localparam int CFG_HF  [NCFG] = '{16,  2, 3};
  localparam int CFG_HS  [NCFG] = '{96,  2, 4};
  localparam int CFG_HB  [NCFG] = '{48,  2, 5};
  localparam int CFG_VP  [NCFG] = '{480, 4, 12};
  localparam int CFG_VF  [NCFG] = '{10,  1, 2};
  localparam int CFG_VS  [NCFG] = '{2,   1, 2};
  localparam int CFG_VB  [NCFG] = '{33,  1, 3};
  localparam int CFG_DIV [NCFG] = '{4,   1, 3};

  typedef struct {
    longint cyc;
    int     h;
    int     v;
    bit     le;
    bit     fe;
    bit     va;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en [NCFG];
  logic        pt [NCFG];
  logic        le [NCFG];
  logic        fe [NCFG];
  logic        va [NCFG];
  logic [11:0] hc [NCFG];
  logic [11:0] vc [NCFG];

  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int g, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cfg%0d cyc=%0d: got %0d, expected %0d", name, g, cyc, act, exp);
    end
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int HT  = CFG_HP[g] + CFG_HF[g] + CFG_HS[g] + CFG_HB[g];
    localparam int VT  = CFG_VP[g] + CFG_VF[g] + CFG_VS[g] + CFG_VB[g];
    localparam int DIV = CFG_DIV[g];

    vga_timing_counter #(
      .HPIXEL        (CFG_HP[g]),
      .H_FRONT_PORCH (CFG_HF[g]),
      .H_SYNC_PULSE  (CFG_HS[g]),
      .H_BACK_PORCH  (CFG_HB[g]),
      .VPIXEL        (CFG_VP[g]),
      .V_FRONT_PORCH (CFG_VF[g]),
      .V_SYNC_PULSE  (CFG_VS[g]),
      .V_BACK_PORCH  (CFG_VB[g]),
      .CLK_DIV       (DIV)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en[g]),
      .pix_tick     (pt[g]),
      .hCount       (hc[g]),
      .vCount       (vc[g]),
      .video_active (va[g]),
      .line_end     (le[g]),
      .frame_end    (fe[g])
    );

    exp_t   q[$];
    longint en_cycles;
    longint last_le;
    longint last_fe;

    // Reference: the k-th enabled clock since reset ends a tick when k mod DIV == DIV-1;
    // the raster position is just the number of completed ticks folded by HT and VT.
    initial begin : model
      longint ticks;
      exp_t   e;
      en_cycles = 0;
      forever begin
        @(negedge clk or posedge rst);
        if (rst) begin
          en_cycles = 0;
        end else if (en[g]) begin
          if (en_cycles % DIV == DIV - 1) begin
            ticks = en_cycles / DIV;
            e.cyc = cyc;
            e.h   = int'(ticks % HT);
            e.v   = int'((ticks / HT) % VT);
            e.le  = (e.h == HT - 1);
            e.fe  = e.le && (e.v == VT - 1);
            e.va  = (e.h < CFG_HP[g]) && (e.v < CFG_VP[g]);
            q.push_back(e);
          end
          en_cycles++;
        end
      end
    end

    initial begin : monitor
      exp_t e;
      bit   exp_tick;
      last_le = -1;
      last_fe = -1;
      forever begin
        @(negedge clk);
        #1;
        if (rst) begin
          q.delete();
          last_le = -1;
          last_fe = -1;
        end else begin
          if (!en[g]) begin
            last_le = -1;
            last_fe = -1;
          end
          exp_tick = (q.size() > 0) && (q[0].cyc == cyc);
          check("pix_tick", g, longint'(pt[g]), longint'(exp_tick));
          if (exp_tick) begin
            e = q.pop_front();
            if (pt[g]) begin
              check("hCount", g, longint'(hc[g]), longint'(e.h));
              check("vCount", g, longint'(vc[g]), longint'(e.v));
              check("line_end", g, longint'(le[g]), longint'(e.le));
              check("frame_end", g, longint'(fe[g]), longint'(e.fe));
              check("video_active", g, longint'(va[g]), longint'(e.va));
              if (le[g]) begin
                if (last_le >= 0) check("line_period", g, cyc - last_le, longint'(HT * DIV));
                last_le = cyc;
              end
              if (fe[g]) begin
                if (last_fe >= 0) check("frame_period", g, cyc - last_fe, longint'(HT * VT * DIV));
                last_fe = cyc;
              end
            end
          end else begin
            check("line_end_idle", g, longint'(le[g]), 0);
            check("frame_end_idle", g, longint'(fe[g]), 0);
          end
          while (q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
        end
      end
    end
  end

  // With CLK_DIV=1 the strobe is simply en, even while reset holds the counters.
  task automatic check_reset_all(input string tag);
    for (int g = 0; g < NCFG; g++) begin
      check({tag, "_pix_tick"}, g, longint'(pt[g]), (CFG_DIV[g] == 1) ? longint'(en[g]) : 0);
      check({tag, "_hCount"}, g, longint'(hc[g]), 0);
      check({tag, "_vCount"}, g, longint'(vc[g]), 0);
      check({tag, "_line_end"}, g, longint'(le[g]), 0);
      check({tag, "_frame_end"}, g, longint'(fe[g]), 0);
      check({tag, "_video_active"}, g, longint'(va[g]), 1);
    end
  endtask

  task automatic step_random_en(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NCFG; g++) en[g] = ($urandom_range(0, 7) != 0);
    end
  endtask

  initial begin
    int waited;
    int k;
    rst = 1'b1;
    for (int g = 0; g < NCFG; g++) en[g] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_all("reset");

    rst = 1'b0;
    for (int g = 0; g < NCFG; g++) en[g] = 1'b1;
    repeat (6500) @(posedge clk);
    #1;

    // Freeze cfg0 mid-line at hCount=300 with a random divider phase.
    waited = 0;
    while (hc[0] != 12'd300 && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("reach_h300", 0, longint'(hc[0]), 300);
    k = $urandom_range(0, 3);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
    en[0] = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("frozen_hCount", 0, longint'(hc[0]), 300);
      check("frozen_pix_tick", 0, longint'(pt[0]), 0);
    end
    en[0] = 1'b1;
    waited = 0;
    while (hc[0] == 12'd300 && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("resume_hCount", 0, longint'(hc[0]), 301);
    check("resume_phase", 0, longint'(waited), longint'(4 - k));

    step_random_en(15000);

    repeat (6) begin
      @(posedge clk);
      #($urandom_range(1, 8));
      rst = 1'b1;
      #1;
      check_reset_all("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step_random_en($urandom_range(200, 2500));
    end

    @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) en[g] = 1'b1;
    repeat (4000) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
